// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Alternating priority under contention, combinational grant, 1-cycle registered read return.
module mem_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [n-1:0] m0_addr,
  input  logic [n-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [n-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [n-1:0] m1_addr,
  input  logic [n-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [n-1:0] m1_rdata,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata
);

  typedef enum logic {
    PRIO_M0 = 1'b0,
    PRIO_M1 = 1'b1
  } prio_e;

  prio_e        r_prio;
  logic         r_m0_rvalid;
  logic         r_m1_rvalid;
  logic [n-1:0] r_m0_rdata;
  logic [n-1:0] r_m1_rdata;
  logic         w_gnt0;
  logic         w_gnt1;

  // Reset masks grants in the same cycle, so a read granted under reset is dropped.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        w_gnt0 = (r_prio == PRIO_M0);
        w_gnt1 = (r_prio == PRIO_M1);
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= PRIO_M0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      if (w_gnt0) begin
        r_prio <= PRIO_M1;
      end else if (w_gnt1) begin
        r_prio <= PRIO_M0;
      end
      r_m0_rvalid <= w_gnt0 && !m0_we;
      r_m1_rvalid <= w_gnt1 && !m1_we;
      if (w_gnt0 && !m0_we) begin
        r_m0_rdata <= mem_rdata;
      end
      if (w_gnt1 && !m1_we) begin
        r_m1_rdata <= mem_rdata;
      end
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus constrained-random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        env_clr;
  logic [31:0] env_mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          mdl_prio;
  logic        mdl_rv [2];
  logic [31:0] mdl_rd [2];
  logic [31:0] ref_mem [64];
  logic        mg0, mg1;

  mem_arbiter #(.n(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write at the edge.
  assign mem_rdata = env_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= '0;
    end else if (mem_we) begin
      env_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, check grant/memory side, advance model, check read return.
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    int          winner;
    logic [31:0] ea, ed;
    logic        ewe;
    @(negedge clk);
    reset = rst;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    if (rst)            winner = -1;
    else if (r0 && r1)  winner = mdl_prio;
    else if (r0)        winner = 0;
    else if (r1)        winner = 1;
    else                winner = -1;
    mg0 = (winner == 0);
    mg1 = (winner == 1);
    ewe = (winner == 0) ? w0 : (winner == 1) ? w1 : 1'b0;
    ea  = (winner == 0) ? a0 : (winner == 1) ? a1 : 32'h0;
    ed  = (winner == 0) ? d0 : (winner == 1) ? d1 : 32'h0;
    check("m0_gnt", 32'(m0_gnt), 32'(mg0));
    check("m1_gnt", 32'(m1_gnt), 32'(mg1));
    check("mem_we", 32'(mem_we), 32'(ewe));
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    @(posedge clk);
    if (rst) begin
      mdl_prio = 0;
      mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
      mdl_rd[0] = '0;   mdl_rd[1] = '0;
    end else begin
      mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
      if (winner >= 0) begin
        if (ewe) ref_mem[ea[7:2]] = ed;
        else begin
          mdl_rv[winner] = 1'b1;
          mdl_rd[winner] = ref_mem[ea[7:2]];
        end
        mdl_prio = 1 - winner;
      end
    end
    #1;
    check("m0_rvalid", 32'(m0_rvalid), 32'(mdl_rv[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(mdl_rv[1]));
    check("m0_rdata", m0_rdata, mdl_rd[0]);
    check("m1_rdata", m1_rdata, mdl_rd[1]);
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        q_r0, q_w0, q_r1, q_w1, rst;
    logic [31:0] q_a0, q_d0, q_a1, q_d1;

    mdl_prio = 0;
    mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
    mdl_rd[0] = '0;   mdl_rd[1] = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    reset = 1'b1; env_clr = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    env_clr = 1'b0;

    // Reset with both masters requesting: no grant, clean memory side.
    step(1'b1, 1'b1, 1'b1, 32'h44, 32'h1, 1'b1, 1'b0, 32'h48, 32'h2);
    idle(1'b1);

    // m1 write, m0 idle.
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    check("r035_m1_rvalid", 32'(m1_rvalid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);

    // Reset, then m0 read of 0x10.
    idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("r034_m0_rvalid", 32'(m0_rvalid), 32'h1);
    check("r034_m0_rdata", m0_rdata, 32'hDEADBEEF);
    // prio now favours m1: contention must grant m1.
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("r034_prio_m1_gnt", 32'(mg1), 32'h1);
    check("r034_m1_rdata", m1_rdata, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("r034_m0_rdata2", m0_rdata, 32'h12345678);

    // Contention from reset: m0, m1, m0, m1.
    idle(1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      check("r036_alt", 32'(m1_rvalid), 32'(c % 2));
    end

    // m0 alone for 3 cycles, then m1 joins and wins first.
    idle(1'b1);
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("r037_m1_first", 32'(m1_rvalid), 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);

    // Reset during an m1 read grant drops the read.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("r038_m1_rvalid", 32'(m1_rvalid), 32'h0);
    check("r038_m1_rdata", m1_rdata, 32'h0);

    // Simultaneous writes with prio = 0: m0 first, m1 next, then read back.
    step(1'b0, 1'b1, 1'b1, 32'h30, 32'hAAAA0000, 1'b1, 1'b1, 32'h34, 32'h0000BBBB);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h34, 32'h0000BBBB);
    step(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
    check("r039_m0_rd", m0_rdata, 32'hAAAA0000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
    check("r039_m1_rd", m1_rdata, 32'h0000BBBB);

    // Random traffic; a request that lost arbitration is held unchanged.
    q_r0 = 0; q_w0 = 0; q_a0 = 0; q_d0 = 0;
    q_r1 = 0; q_w1 = 0; q_a1 = 0; q_d1 = 0;
    mg0 = 0; mg1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(q_r0 && !mg0)) begin
        q_r0 = ($urandom_range(0, 3) != 0);
        q_w0 = $urandom_range(0, 1) == 1;
        q_a0 = 32'($urandom_range(0, 63)) << 2;
        q_d0 = $urandom;
      end
      if (!(q_r1 && !mg1)) begin
        q_r1 = ($urandom_range(0, 3) != 0);
        q_w1 = $urandom_range(0, 1) == 1;
        q_a1 = 32'($urandom_range(0, 63)) << 2;
        q_d1 = $urandom;
      end
      rst = ($urandom_range(0, 49) == 0);
      step(rst, q_r0, q_w0, q_a0, q_d0, q_r1, q_w1, q_a1, q_d1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
